// File: rtl/lockstep_pkg.sv
// Shared types for the lockstep data-memory gate.
//   state_e        : gate FSM states
//   fault_cause_e  : encoding reported on fault_cause_o
//   mem_req_t      : one core-side (or memory-side) data request
//   be_to_mask     : expands byte enables into a per-bit data mask
// The request struct is sized by LS_ADDR_W / LS_DATA_W; instances of the
// gate are expected to use these widths for ADDR_W / DATA_W.
package lockstep_pkg;

  localparam int LS_ADDR_W = 32;
  localparam int LS_DATA_W = 32;
  localparam int LS_BE_W   = LS_DATA_W / 8;

  typedef enum logic [2:0] {
    IDLE,
    WAIT_PEER,
    ISSUE,
    RESP,
    FAULT
  } state_e;

  typedef enum logic [1:0] {
    NONE     = 2'b00,
    MISMATCH = 2'b01,
    TIMEOUT  = 2'b10
  } fault_cause_e;

  typedef struct packed {
    logic                 we;
    logic [LS_BE_W-1:0]   be;
    logic [LS_ADDR_W-1:0] addr;
    logic [LS_DATA_W-1:0] wdata;
  } mem_req_t;

  function automatic logic [LS_DATA_W-1:0] be_to_mask(input logic [LS_BE_W-1:0] be);
    logic [LS_DATA_W-1:0] m;
    m = '0;
    for (int i = 0; i < LS_BE_W; i++) begin
      m[8*i +: 8] = {8{be[i]}};
    end
    return m;
  endfunction

endpackage

// File: rtl/lockstep_req_cmp.sv
// Combinational comparator for two lockstep data requests.
//   req_a, req_b : requests from core A and core B
//   match        : 1 when we, addr and be agree and, for writes, the write
//                  data agrees on every enabled byte
module lockstep_req_cmp
  import lockstep_pkg::*;
(
  input  mem_req_t req_a,
  input  mem_req_t req_b,
  output logic     match
);

  logic [LS_DATA_W-1:0] mask;
  logic                 ctrl_eq;
  logic                 data_eq;

  // be must already be equal for a match, so A's enables define the mask.
  always_comb begin
    mask    = be_to_mask(req_a.be);
    ctrl_eq = (req_a.we == req_b.we) && (req_a.addr == req_b.addr) &&
              (req_a.be == req_b.be);
    data_eq = ((req_a.wdata ^ req_b.wdata) & mask) == '0;
    match   = ctrl_eq && (!req_a.we || data_eq);
  end

endmodule

// File: rtl/lockstep_mem_gate.sv
// Lockstep data-memory gate: merges the data ports of two lockstep cores
// into a single memory port. Both requests must agree before one memory
// transaction is issued; disagreement or excessive skew raises a sticky
// fault that blocks memory access until clear_fault_i.
//   a_* / b_*      : core-side request inputs and gnt/rvalid/rdata outputs
//   mem_*          : single memory-side port
//   clear_fault_i  : leave the FAULT state
//   fault_o        : sticky fault flag (high while in FAULT)
//   fault_cause_o  : 00 none, 01 mismatch, 10 timeout
//   mismatch_o     : one-cycle pulse on FAULT entry
//   err_count_o    : saturating count of FAULT entries (cleared by rst_i only)
module lockstep_mem_gate
  import lockstep_pkg::*;
#(
  parameter int ADDR_W    = LS_ADDR_W,
  parameter int DATA_W    = LS_DATA_W,
  parameter int SKEW_MAX  = 16,
  parameter int ERR_CNT_W = 8
) (
  input  logic                 clk_i,
  input  logic                 rst_i,

  input  logic                 a_req_i,
  input  logic                 a_we_i,
  input  logic [DATA_W/8-1:0]  a_be_i,
  input  logic [ADDR_W-1:0]    a_addr_i,
  input  logic [DATA_W-1:0]    a_wdata_i,
  output logic                 a_gnt_o,
  output logic                 a_rvalid_o,
  output logic [DATA_W-1:0]    a_rdata_o,

  input  logic                 b_req_i,
  input  logic                 b_we_i,
  input  logic [DATA_W/8-1:0]  b_be_i,
  input  logic [ADDR_W-1:0]    b_addr_i,
  input  logic [DATA_W-1:0]    b_wdata_i,
  output logic                 b_gnt_o,
  output logic                 b_rvalid_o,
  output logic [DATA_W-1:0]    b_rdata_o,

  output logic                 mem_req_o,
  output logic                 mem_we_o,
  output logic [DATA_W/8-1:0]  mem_be_o,
  output logic [ADDR_W-1:0]    mem_addr_o,
  output logic [DATA_W-1:0]    mem_wdata_o,
  input  logic                 mem_gnt_i,
  input  logic                 mem_rvalid_i,
  input  logic [DATA_W-1:0]    mem_rdata_i,

  input  logic                 clear_fault_i,
  output logic                 fault_o,
  output logic [1:0]           fault_cause_o,
  output logic                 mismatch_o,
  output logic [ERR_CNT_W-1:0] err_count_o
);

  localparam int SKEW_W = (SKEW_MAX > 2) ? $clog2(SKEW_MAX) : 1;

  function automatic logic [ERR_CNT_W-1:0] sat_inc(input logic [ERR_CNT_W-1:0] v);
    return (&v) ? v : v + 1'b1;
  endfunction

  state_e               state_q, state_d;
  fault_cause_e         cause_q, cause_d;
  mem_req_t             cap_q, cap_d;
  mem_req_t             a_req_s, b_req_s;
  logic [SKEW_W-1:0]    cnt_q, cnt_d, cnt_inc;
  logic                 wait_a_q, wait_a_d;
  logic                 mismatch_q;
  logic [ERR_CNT_W-1:0] err_q;
  logic                 match;
  logic                 peer_req;
  logic                 fault_entry;

  always_comb begin
    a_req_s.we    = a_we_i;
    a_req_s.be    = a_be_i;
    a_req_s.addr  = a_addr_i;
    a_req_s.wdata = a_wdata_i;
    b_req_s.we    = b_we_i;
    b_req_s.be    = b_be_i;
    b_req_s.addr  = b_addr_i;
    b_req_s.wdata = b_wdata_i;
  end

  lockstep_req_cmp u_cmp (
    .req_a (a_req_s),
    .req_b (b_req_s),
    .match (match)
  );

  // State and bookkeeping registers
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q    <= IDLE;
      cause_q    <= NONE;
      cap_q      <= '0;
      cnt_q      <= '0;
      wait_a_q   <= 1'b0;
      mismatch_q <= 1'b0;
      err_q      <= '0;
    end else begin
      state_q    <= state_d;
      cause_q    <= cause_d;
      cap_q      <= cap_d;
      cnt_q      <= cnt_d;
      wait_a_q   <= wait_a_d;
      mismatch_q <= fault_entry;
      if (fault_entry) begin
        err_q <= sat_inc(err_q);
      end
    end
  end

  // Next-state logic
  always_comb begin
    state_d  = state_q;
    cause_d  = cause_q;
    cap_d    = cap_q;
    cnt_d    = cnt_q;
    wait_a_d = wait_a_q;
    // The request still outstanding is the one from the core not recorded.
    peer_req = wait_a_q ? b_req_i : a_req_i;
    // Timeout is judged on the incremented value so that the fault lands
    // SKEW_MAX cycles after the first lone request was seen.
    cnt_inc  = cnt_q + SKEW_W'(1);

    case (state_q)
      IDLE: begin
        if (a_req_i && b_req_i) begin
          if (match) begin
            cap_d   = a_req_s;
            state_d = ISSUE;
          end else begin
            cause_d = MISMATCH;
            state_d = FAULT;
          end
        end else if (a_req_i || b_req_i) begin
          wait_a_d = a_req_i;
          cnt_d    = '0;
          state_d  = WAIT_PEER;
        end
      end
      WAIT_PEER: begin
        cnt_d = cnt_inc;
        // A peer request arriving in the timeout cycle takes priority.
        if (peer_req) begin
          if (match) begin
            cap_d   = a_req_s;
            state_d = ISSUE;
          end else begin
            cause_d = MISMATCH;
            state_d = FAULT;
          end
        end else if (cnt_inc == SKEW_W'(SKEW_MAX - 1)) begin
          cause_d = TIMEOUT;
          state_d = FAULT;
        end
      end
      ISSUE: begin
        if (mem_gnt_i) begin
          state_d = RESP;
        end
      end
      RESP: begin
        if (mem_rvalid_i) begin
          state_d = IDLE;
        end
      end
      FAULT: begin
        if (clear_fault_i) begin
          cause_d = NONE;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase

    fault_entry = (state_q != FAULT) && (state_d == FAULT);
  end

  // Output logic
  always_comb begin
    mem_req_o   = 1'b0;
    mem_we_o    = 1'b0;
    mem_be_o    = '0;
    mem_addr_o  = '0;
    mem_wdata_o = '0;
    a_gnt_o     = 1'b0;
    b_gnt_o     = 1'b0;
    a_rvalid_o  = 1'b0;
    b_rvalid_o  = 1'b0;
    a_rdata_o   = '0;
    b_rdata_o   = '0;

    if (state_q == ISSUE) begin
      mem_req_o   = 1'b1;
      mem_we_o    = cap_q.we;
      mem_be_o    = cap_q.be;
      mem_addr_o  = cap_q.addr;
      mem_wdata_o = cap_q.wdata;
      a_gnt_o     = mem_gnt_i;
      b_gnt_o     = mem_gnt_i;
    end

    // rdata is forced to zero whenever rvalid is low.
    if (state_q == RESP && mem_rvalid_i) begin
      a_rvalid_o = 1'b1;
      b_rvalid_o = 1'b1;
      a_rdata_o  = mem_rdata_i;
      b_rdata_o  = mem_rdata_i;
    end

    fault_o       = (state_q == FAULT);
    fault_cause_o = cause_q;
    mismatch_o    = mismatch_q;
    err_count_o   = err_q;
  end

endmodule

// File: tb/tb_lockstep_mem_gate.sv
module tb_lockstep_mem_gate;

  localparam int AW = 32;
  localparam int DW = 32;
  localparam int BW = DW / 8;
  localparam int EW = 2;

  logic          clk = 1'b0;
  logic          rst;
  logic          a_req, a_we, b_req, b_we;
  logic [BW-1:0] a_be, b_be;
  logic [AW-1:0] a_addr, b_addr;
  logic [DW-1:0] a_wdata, b_wdata;
  logic          a_gnt, a_rvalid, b_gnt, b_rvalid;
  logic [DW-1:0] a_rdata, b_rdata;
  logic          mem_req, mem_we, mem_gnt, mem_rvalid;
  logic [BW-1:0] mem_be;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata, mem_rdata;
  logic          clear_fault, fault, mismatch;
  logic [1:0]    fault_cause;
  logic [EW-1:0] err_count;

  int checks = 0;
  int errors = 0;
  int hs_cnt = 0;

  always #5 clk = ~clk;

  lockstep_mem_gate #(
    .ADDR_W(AW), .DATA_W(DW), .SKEW_MAX(16), .ERR_CNT_W(EW)
  ) dut (
    .clk_i(clk), .rst_i(rst),
    .a_req_i(a_req), .a_we_i(a_we), .a_be_i(a_be), .a_addr_i(a_addr),
    .a_wdata_i(a_wdata), .a_gnt_o(a_gnt), .a_rvalid_o(a_rvalid), .a_rdata_o(a_rdata),
    .b_req_i(b_req), .b_we_i(b_we), .b_be_i(b_be), .b_addr_i(b_addr),
    .b_wdata_i(b_wdata), .b_gnt_o(b_gnt), .b_rvalid_o(b_rvalid), .b_rdata_o(b_rdata),
    .mem_req_o(mem_req), .mem_we_o(mem_we), .mem_be_o(mem_be), .mem_addr_o(mem_addr),
    .mem_wdata_o(mem_wdata), .mem_gnt_i(mem_gnt), .mem_rvalid_i(mem_rvalid),
    .mem_rdata_i(mem_rdata),
    .clear_fault_i(clear_fault), .fault_o(fault), .fault_cause_o(fault_cause),
    .mismatch_o(mismatch), .err_count_o(err_count)
  );

  // Count accepted memory transactions.
  always @(posedge clk) begin
    if (!rst && mem_req && mem_gnt) hs_cnt <= hs_cnt + 1;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    a_req = 0; a_we = 0; a_be = '0; a_addr = '0; a_wdata = '0;
    b_req = 0; b_we = 0; b_be = '0; b_addr = '0; b_wdata = '0;
    mem_gnt = 0; mem_rvalid = 0; mem_rdata = '0; clear_fault = 0;
  endtask

  task automatic set_a(input logic we, input logic [BW-1:0] be,
                       input logic [AW-1:0] addr, input logic [DW-1:0] wd);
    a_req = 1; a_we = we; a_be = be; a_addr = addr; a_wdata = wd;
  endtask

  task automatic set_b(input logic we, input logic [BW-1:0] be,
                       input logic [AW-1:0] addr, input logic [DW-1:0] wd);
    b_req = 1; b_we = we; b_be = be; b_addr = addr; b_wdata = wd;
  endtask

  task automatic do_reset();
    idle_inputs();
    rst = 1;
    cyc();
    cyc();
    rst = 0;
  endtask

  task automatic test_reset();
    do_reset();
    checks++;
    if ({mem_req, a_gnt, b_gnt, a_rvalid, b_rvalid, fault, mismatch} !== 7'b0) begin
      errors++;
      $display("FAIL reset_ctrl: got %b exp 0000000",
               {mem_req, a_gnt, b_gnt, a_rvalid, b_rvalid, fault, mismatch});
    end
    checks++;
    if ({fault_cause, err_count} !== 4'b0) begin
      errors++;
      $display("FAIL reset_fault: cause %b count %0d exp 00/0", fault_cause, err_count);
    end
    checks++;
    if ({a_rdata, b_rdata, mem_addr, mem_wdata} !== '0) begin
      errors++;
      $display("FAIL reset_data: rdata/mem fields not zero");
    end
  endtask

  task automatic test_matched_write();
    int hs0;
    do_reset();
    hs0 = hs_cnt;
    set_a(1, 4'hF, 32'h100, 32'hDEADBEEF);
    set_b(1, 4'hF, 32'h100, 32'hDEADBEEF);
    #1;
    checks++;
    if (mem_req !== 1'b0) begin
      errors++; $display("FAIL mw_early_req: got %b exp 0", mem_req);
    end
    cyc();
    checks++;
    if ({mem_req, mem_we, mem_be, mem_addr, mem_wdata} !== {1'b1, 1'b1, 4'hF, 32'h100, 32'hDEADBEEF}) begin
      errors++;
      $display("FAIL mw_issue: req %b we %b be %h addr %h wdata %h exp 1 1 f 100 deadbeef",
               mem_req, mem_we, mem_be, mem_addr, mem_wdata);
    end
    checks++;
    if ({a_gnt, b_gnt} !== 2'b00) begin
      errors++; $display("FAIL mw_gnt_before: got %b exp 00", {a_gnt, b_gnt});
    end
    cyc();
    cyc();
    mem_gnt = 1;
    #1;
    checks++;
    if ({a_gnt, b_gnt, mem_req} !== 3'b111) begin
      errors++; $display("FAIL mw_gnt: got %b exp 111", {a_gnt, b_gnt, mem_req});
    end
    cyc();
    a_req = 0; b_req = 0; mem_gnt = 0;
    #1;
    checks++;
    if ({mem_req, fault, a_gnt} !== 3'b000) begin
      errors++; $display("FAIL mw_resp: req/fault/gnt %b exp 000", {mem_req, fault, a_gnt});
    end
    mem_rvalid = 1;
    #1;
    checks++;
    if ({a_rvalid, b_rvalid} !== 2'b11) begin
      errors++; $display("FAIL mw_rvalid: got %b exp 11", {a_rvalid, b_rvalid});
    end
    cyc();
    mem_rvalid = 0;
    checks++;
    if (hs_cnt - hs0 !== 1) begin
      errors++; $display("FAIL mw_txn_count: got %0d exp 1", hs_cnt - hs0);
    end
  endtask

  task automatic test_skewed_read();
    int hs0;
    do_reset();
    hs0 = hs_cnt;
    set_a(0, 4'hF, 32'h40, 32'h0);
    for (int i = 0; i < 5; i++) cyc();
    checks++;
    if (mem_req !== 1'b0) begin
      errors++; $display("FAIL sr_wait_req: got %b exp 0", mem_req);
    end
    set_b(0, 4'hF, 32'h40, 32'h0);
    cyc();
    checks++;
    if ({mem_req, mem_we, mem_addr} !== {1'b1, 1'b0, 32'h40}) begin
      errors++;
      $display("FAIL sr_issue: req %b we %b addr %h exp 1 0 40", mem_req, mem_we, mem_addr);
    end
    mem_gnt = 1;
    cyc();
    a_req = 0; b_req = 0; mem_gnt = 0;
    mem_rvalid = 1; mem_rdata = 32'h12345678;
    #1;
    checks++;
    if ({a_rvalid, b_rvalid, a_rdata, b_rdata} !== {2'b11, 32'h12345678, 32'h12345678}) begin
      errors++;
      $display("FAIL sr_rdata: rvalid %b a %h b %h exp 11 12345678", {a_rvalid, b_rvalid},
               a_rdata, b_rdata);
    end
    cyc();
    mem_rvalid = 0;
    #1;
    checks++;
    if ({a_rdata, err_count, fault} !== {32'h0, 2'd0, 1'b0}) begin
      errors++;
      $display("FAIL sr_after: rdata %h err %0d fault %b exp 0 0 0", a_rdata, err_count, fault);
    end
    checks++;
    if (hs_cnt - hs0 !== 1) begin
      errors++; $display("FAIL sr_txn_count: got %0d exp 1", hs_cnt - hs0);
    end
  endtask

  task automatic test_masked_write();
    do_reset();
    set_a(1, 4'b0011, 32'h200, 32'hAAAA1234);
    set_b(1, 4'b0011, 32'h200, 32'h55551234);
    cyc();
    checks++;
    if ({mem_req, mem_be, mem_wdata, fault} !== {1'b1, 4'b0011, 32'hAAAA1234, 1'b0}) begin
      errors++;
      $display("FAIL mk_issue: req %b be %h wdata %h fault %b exp 1 3 aaaa1234 0",
               mem_req, mem_be, mem_wdata, fault);
    end
    mem_gnt = 1;
    cyc();
    a_req = 0; b_req = 0; mem_gnt = 0; mem_rvalid = 1;
    cyc();
    mem_rvalid = 0;
    set_a(1, 4'b0011, 32'h200, 32'hAAAA1234);
    set_b(1, 4'b0011, 32'h200, 32'h55551235);
    cyc();
    checks++;
    if ({fault, fault_cause, mismatch, err_count, mem_req, a_gnt} !== {1'b1, 2'b01, 1'b1, 2'd1, 1'b0, 1'b0}) begin
      errors++;
      $display("FAIL mk_fault: fault %b cause %b pulse %b err %0d req %b gnt %b exp 1 01 1 1 0 0",
               fault, fault_cause, mismatch, err_count, mem_req, a_gnt);
    end
    cyc();
    checks++;
    if ({fault, mismatch, mem_req} !== 3'b100) begin
      errors++;
      $display("FAIL mk_sticky: fault/pulse/req %b exp 100", {fault, mismatch, mem_req});
    end
    a_req = 0; b_req = 0; clear_fault = 1;
    cyc();
    clear_fault = 0;
    checks++;
    if ({fault, fault_cause, err_count} !== {1'b0, 2'b00, 2'd1}) begin
      errors++;
      $display("FAIL mk_clear: fault %b cause %b err %0d exp 0 00 1", fault, fault_cause, err_count);
    end
  endtask

  task automatic test_timeout();
    do_reset();
    set_a(0, 4'hF, 32'h80, 32'h0);
    for (int i = 1; i <= 16; i++) begin
      cyc();
      if (i == 15) begin
        checks++;
        if (fault !== 1'b0) begin
          errors++; $display("FAIL to_early: fault %b at cycle 15 exp 0", fault);
        end
      end
    end
    checks++;
    if ({fault, fault_cause, mismatch, err_count} !== {1'b1, 2'b10, 1'b1, 2'd1}) begin
      errors++;
      $display("FAIL to_fault: fault %b cause %b pulse %b err %0d exp 1 10 1 1",
               fault, fault_cause, mismatch, err_count);
    end
    a_req = 0; clear_fault = 1;
    cyc();
    clear_fault = 0;
    checks++;
    if ({fault, fault_cause, err_count} !== {1'b0, 2'b00, 2'd1}) begin
      errors++;
      $display("FAIL to_clear: fault %b cause %b err %0d exp 0 00 1", fault, fault_cause, err_count);
    end
  endtask

  task automatic test_peer_wins();
    do_reset();
    set_b(0, 4'hF, 32'hC0, 32'h0);
    for (int i = 1; i <= 15; i++) cyc();
    set_a(0, 4'hF, 32'hC0, 32'h0);
    cyc();
    checks++;
    if ({mem_req, fault, mem_addr} !== {1'b1, 1'b0, 32'hC0}) begin
      errors++;
      $display("FAIL pw_issue: req %b fault %b addr %h exp 1 0 c0", mem_req, fault, mem_addr);
    end
    mem_gnt = 1;
    cyc();
    a_req = 0; b_req = 0; mem_gnt = 0; mem_rvalid = 1;
    cyc();
    mem_rvalid = 0;
  endtask

  task automatic test_saturation();
    do_reset();
    for (int n = 1; n <= 5; n++) begin
      set_a(0, 4'hF, 32'h10, 32'h0);
      set_b(0, 4'hF, 32'h14, 32'h0);
      cyc();
      if (n == 2) begin
        checks++;
        if (err_count !== 2'd2) begin
          errors++; $display("FAIL sat_two: err %0d exp 2", err_count);
        end
      end
      a_req = 0; b_req = 0; clear_fault = 1;
      cyc();
      clear_fault = 0;
    end
    checks++;
    if (err_count !== 2'd3) begin
      errors++; $display("FAIL sat_final: err %0d exp 3", err_count);
    end
  endtask

  task automatic test_reset_mid_resp();
    do_reset();
    set_a(0, 4'hF, 32'h300, 32'h0);
    set_b(0, 4'hF, 32'h300, 32'h0);
    cyc();
    mem_gnt = 1;
    cyc();
    a_req = 0; b_req = 0; mem_gnt = 0;
    rst = 1;
    cyc();
    rst = 0;
    checks++;
    if ({mem_req, fault, err_count} !== {1'b0, 1'b0, 2'd0}) begin
      errors++;
      $display("FAIL rr_outputs: req %b fault %b err %0d exp 0 0 0", mem_req, fault, err_count);
    end
    mem_rvalid = 1; mem_rdata = 32'hCAFEF00D;
    #1;
    checks++;
    if ({a_rvalid, b_rvalid, a_rdata, b_rdata} !== '0) begin
      errors++;
      $display("FAIL rr_late_rvalid: rvalid %b a %h b %h exp 00 0 0", {a_rvalid, b_rvalid},
               a_rdata, b_rdata);
    end
    cyc();
    mem_rvalid = 0;
    set_a(0, 4'hF, 32'h304, 32'h0);
    set_b(0, 4'hF, 32'h304, 32'h0);
    cyc();
    checks++;
    if ({mem_req, mem_addr} !== {1'b1, 32'h304}) begin
      errors++; $display("FAIL rr_next: req %b addr %h exp 1 304", mem_req, mem_addr);
    end
    mem_gnt = 1;
    cyc();
    a_req = 0; b_req = 0; mem_gnt = 0; mem_rvalid = 1; mem_rdata = 32'h0BADCAFE;
    #1;
    checks++;
    if ({a_rvalid, a_rdata} !== {1'b1, 32'h0BADCAFE}) begin
      errors++; $display("FAIL rr_next_resp: rvalid %b rdata %h exp 1 0badcafe", a_rvalid, a_rdata);
    end
    cyc();
    mem_rvalid = 0;
  endtask

  initial begin
    rst = 1;
    idle_inputs();
    test_reset();
    test_matched_write();
    test_skewed_read();
    test_masked_write();
    test_timeout();
    test_peer_wins();
    test_saturation();
    test_reset_mid_resp();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/lockstep_mem_gate.md
Name: lockstep_mem_gate

Overview:
- Sits between the two lockstep zeroriscy cores' data ports and the single data memory. It is the consumer of both cores' data-side requests.
- Waits for both cores to issue a request and compares them (we, addr, be, byte-masked wdata).
- On a match, issues exactly one memory transaction and returns grant, rvalid and rdata to both cores.
- On a mismatch or excessive skew, blocks memory access and raises a sticky fault.

Parameters:
- ADDR_W, 32, address width.
- DATA_W, 32, data width; must be a multiple of 8.
- SKEW_MAX, 16, max cycles one core may wait for its peer before a timeout fault.
- ERR_CNT_W, 8, width of the saturating fault counter.

Ports:
- clk_i  in  1  clock.
- rst_i  in  1  synchronous active-high reset.
- a_req_i  in  1  core A data request.
- a_we_i  in  1  core A write enable.
- a_be_i  in  DATA_W/8  core A byte enables.
- a_addr_i  in  ADDR_W  core A address.
- a_wdata_i  in  DATA_W  core A write data.
- a_gnt_o  out  1  grant to core A.
- a_rvalid_o  out  1  response valid to core A.
- a_rdata_o  out  DATA_W  read data to core A.
- b_req_i / b_we_i / b_be_i / b_addr_i / b_wdata_i  in  as core A  core B request.
- b_gnt_o / b_rvalid_o / b_rdata_o  out  as core A  core B response.
- mem_req_o  out  1  memory request.
- mem_we_o  out  1  memory write enable.
- mem_be_o  out  DATA_W/8  memory byte enables.
- mem_addr_o  out  ADDR_W  memory address.
- mem_wdata_o  out  DATA_W  memory write data.
- mem_gnt_i  in  1  memory grant.
- mem_rvalid_i  in  1  memory response valid.
- mem_rdata_i  in  DATA_W  memory read data.
- clear_fault_i  in  1  leave FAULT state.
- fault_o  out  1  sticky fault flag.
- fault_cause_o  out  2  fault cause: 00 none, 01 mismatch, 10 timeout.
- mismatch_o  out  1  one-cycle pulse on FAULT entry.
- err_count_o  out  ERR_CNT_W  saturating count of fault entries.

Behaviour:
- Clock is clk_i; reset rst_i is synchronous, active-high.
- Reset state:
  - FSM in IDLE.
  - All outputs 0 (mem_req_o, gnt, rvalid, fault_o, fault_cause_o=00, mismatch_o, err_count_o).
  - Request buffer cleared.
- Core-side protocol: a core holds req and its fields stable until it sees gnt.
- Comparison (match = all true):
  - we equal; addr equal; be equal.
  - If we=1: wdata equal on bytes where be=1. Bytes with be=0 are ignored.
  - If we=0: wdata ignored.
- FSM states: IDLE, WAIT_PEER, ISSUE, RESP, FAULT.
- IDLE:
  - Both req=1 and match: capture A's fields, go to ISSUE.
  - Both req=1 and mismatch: go to FAULT, cause=01.
  - Exactly one req=1: record which core, clear the skew counter, go to WAIT_PEER.
  - mem_rvalid_i in IDLE is ignored.
- WAIT_PEER:
  - Counter increments each cycle.
  - Peer req=1: compare the live A and B fields. Match: capture, go to ISSUE. Mismatch: go to FAULT, cause=01.
  - Counter reaches SKEW_MAX-1 with no peer req: go to FAULT, cause=10.
  - If peer req and timeout occur in the same cycle, the peer req wins.
- ISSUE:
  - mem_req_o=1, driven from the captured fields (registered). Latency: both reqs at cycle N gives mem_req_o at cycle N+1.
  - a_gnt_o = b_gnt_o = mem_gnt_i, combinational in this state only. Both cores are granted in the same cycle.
  - On mem_gnt_i, go to RESP.
- RESP:
  - mem_req_o=0.
  - a_rvalid_o = b_rvalid_o = mem_rvalid_i; a_rdata_o = b_rdata_o = mem_rdata_i.
  - On mem_rvalid_i, go to IDLE.
  - No new request is accepted before the response; core reqs stay pending and are evaluated in IDLE on the next cycle.
- FAULT:
  - No mem_req_o; gnt held 0, so both cores stall; fault_o=1.
  - On entry: mismatch_o pulses 1 cycle; err_count_o increments, saturating at all-ones.
  - clear_fault_i=1: go to IDLE, fault_o=0, fault_cause_o=00. err_count_o is kept (only rst_i clears it).
- Reset mid-transaction: returns to IDLE immediately, mem_req_o drops. A late mem_rvalid_i is ignored.
- rdata outputs are 0 whenever rvalid is 0.

Decomposition:
- Package lockstep_pkg:
  - state_e enum.
  - fault_cause_e enum (NONE=2'b00, MISMATCH=2'b01, TIMEOUT=2'b10).
  - mem_req_t struct {we, be, addr, wdata}.
- One combinational sub-module, lockstep_req_cmp (two mem_req_t in, match out, byte-masked compare).
- FSM, skew counter and error counter stay in lockstep_mem_gate.

Test Plan:
- Matched write: both cores req same cycle, we=1, addr=0x100, be=4'hF, wdata=0xDEADBEEF; mem_gnt_i 2 cycles after mem_req_o.
  - mem_req_o rises 1 cycle after the reqs with the same fields; both gnt pulse with mem_gnt_i; no fault.
- Skewed read: A req at cycle 0, B at cycle 5, addr=0x40; memory returns 0x12345678.
  - Single mem transaction; both rvalid with rdata=0x12345678; err_count_o=0.
- Masked write: be=4'b0011, wdata A=0xAAAA1234, B=0x55551234.
  - Match, write issued. Repeat with B=0x55551235 -> FAULT, cause=01, mismatch_o pulse, err_count_o=1, mem_req_o stays 0.
- Timeout: only A requests, SKEW_MAX=16.
  - fault_o rises 16 cycles after A's req, cause=10. clear_fault_i -> IDLE, fault_o=0, err_count_o holds 1.
- Saturation: ERR_CNT_W=2, force 5 faults with clears in between -> err_count_o=3.
- Reset mid-RESP: assert rst_i while awaiting rvalid, then pulse mem_rvalid_i.
  - No core rvalid; all outputs 0; next matched request proceeds normally.
